// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data cache memory arbiter.
package arbiter_types;

    localparam int LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RECOVER
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way requester picker: round-robin on a tie, or data cache wins when
// ROUND_ROBIN is 0.
module rr_pick2
    import arbiter_types::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic   req_i,
    input  logic   req_d,
    input  grant_t last_grant,
    output grant_t grant
);

    // On a tie, the instruction side wins only when it did not hold the last grant.
    always_comb begin
        grant = GRANT_D;
        if (req_i && !req_d) begin
            grant = GRANT_I;
        end else if (req_i && req_d && (ROUND_ROBIN != 0) && (last_grant == GRANT_D)) begin
            grant = GRANT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one physical memory line port between the I-cache and D-cache,
// one transaction at a time, with an idle recovery cycle after each response.
module mem_arbiter
    import arbiter_types::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    arb_state_t state;
    grant_t     last_grant;
    grant_t     pick;
    logic       req_i;
    logic       req_d;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    rr_pick2 #(
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_pick (
        .req_i      (req_i),
        .req_d      (req_d),
        .last_grant (last_grant),
        .grant      (pick)
    );

    // Requests are sampled only in IDLE; RECOVER always burns one cycle so the
    // owner can drop its request and memory can return to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i || req_d) begin
                        last_grant <= pick;
                        state      <= (pick == GRANT_I) ? SERVE_I : SERVE_D;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state <= RECOVER;
                    end
                end
                RECOVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // Write dominates when the data cache raises read and write together.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (state)
            SERVE_I: begin
                pmem_read    = i_read;
                pmem_address = i_address;
                i_resp       = pmem_resp;
            end
            SERVE_D: begin
                pmem_write   = d_write;
                pmem_read    = d_read & ~d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                d_resp       = pmem_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a cycle table, reset and fixed-priority sequences,
// then randomized cache traffic against a line-level memory reference.
module tb_mem_arbiter;
    import arbiter_types::*;

    localparam logic [31:0]       I_ADDR  = 32'h0000_1040;
    localparam logic [31:0]       D_ADDR  = 32'h0000_2000;
    localparam logic [LINE_W-1:0] AA_LINE = {32{8'hAA}};
    localparam logic [LINE_W-1:0] D_LINE  = {8{32'h1234_5678}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              i_read, d_read, d_write;
    logic [31:0]       i_address, d_address;
    logic [LINE_W-1:0] d_wdata;
    logic              i_resp, d_resp;
    logic [LINE_W-1:0] i_rdata, d_rdata;
    logic              pmem_read, pmem_write, pmem_resp;
    logic [31:0]       pmem_address;
    logic [LINE_W-1:0] pmem_wdata, pmem_rdata;

    logic              fp_i_resp, fp_d_resp, fp_pmem_read, fp_pmem_write;
    logic [LINE_W-1:0] fp_i_rdata, fp_d_rdata, fp_pmem_wdata;
    logic [31:0]       fp_pmem_address;

    logic              mem_auto = 1'b0;
    logic              man_resp = 1'b0;
    logic              man_resp_fp = 1'b0;
    logic              mem_resp = 1'b0;
    logic [LINE_W-1:0] mem_rdata = '0;
    int                mem_cnt = 0;
    int                mem_lat = 0;
    logic [LINE_W-1:0] pmem_store [logic [31:0]];
    logic [LINE_W-1:0] ref_mem    [logic [31:0]];

    assign pmem_resp  = mem_auto ? mem_resp : man_resp;
    assign pmem_rdata = mem_auto ? mem_rdata : AA_LINE;

    mem_arbiter #(.ROUND_ROBIN(1)) u_dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    mem_arbiter #(.ROUND_ROBIN(0)) u_dut_fp (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_resp(fp_i_resp), .i_rdata(fp_i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(fp_d_resp), .d_rdata(fp_d_rdata),
        .pmem_read(fp_pmem_read), .pmem_write(fp_pmem_write), .pmem_address(fp_pmem_address),
        .pmem_wdata(fp_pmem_wdata), .pmem_resp(man_resp_fp), .pmem_rdata(pmem_rdata)
    );

    function automatic logic [LINE_W-1:0] initLine(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [LINE_W-1:0] memLine(input logic [31:0] a);
        return pmem_store.exists(a) ? pmem_store[a] : initLine(a);
    endfunction

    function automatic logic [LINE_W-1:0] refLine(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : initLine(a);
    endfunction

    // Physical memory: acts shortly after each edge, responds after 0..3 wait cycles.
    always @(posedge clk) begin
        #2;
        if (!mem_auto) begin
            mem_resp = 1'b0;
            mem_cnt  = 0;
        end else if (pmem_read || pmem_write) begin
            if (mem_cnt >= mem_lat) begin
                mem_resp = 1'b1;
                if (pmem_write) pmem_store[pmem_address] = pmem_wdata;
                else            mem_rdata = memLine(pmem_address);
                mem_cnt = 0;
                mem_lat = int'($urandom_range(0, 3));
            end else begin
                mem_resp  = 1'b0;
                mem_rdata = {8{$urandom}};
                mem_cnt++;
            end
        end else begin
            mem_resp  = 1'b0;
            mem_rdata = {8{$urandom}};
            mem_cnt   = 0;
        end
    end

    typedef struct packed {
        logic       ir;
        logic       dr;
        logic       dw;
        logic       resp;
        logic       pr;
        logic       pw;
        logic       iresp;
        logic       dresp;
        logic [1:0] asel;
    } vec_t;

    vec_t vecs [26];
    int   total = 0;
    int   bad = 0;

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                               input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        step();
        i_read   = v.ir;
        d_read   = v.dr;
        d_write  = v.dw;
        man_resp = v.resp;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        man_resp = 1'b0; man_resp_fp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic              i_done, d_done, prev_active, prev_iw, prev_dw, cand_i, cand_d;
    logic              owner, exp_owner, last_owner, active;
    int                gap, i_wait, d_wait, n_i, n_d, op;
    logic [LINE_W-1:0] exp_wdata;
    logic [31:0]       exp_addr;

    initial begin
        vecs = '{
            10'b0000_0000_00, 10'b1000_0000_00, 10'b1000_1000_01, 10'b1001_1010_01,
            10'b0010_0000_00, 10'b0010_0000_00, 10'b0010_0100_10, 10'b0011_0101_10,
            10'b0100_0000_00, 10'b0100_0000_00, 10'b0101_1001_10, 10'b1110_0000_00,
            10'b1110_0000_00, 10'b1111_1010_01, 10'b1110_0000_00, 10'b1110_0000_00,
            10'b1110_0100_10, 10'b1111_0101_10, 10'b0001_0000_00, 10'b0001_0000_00,
            10'b0000_0000_00, 10'b1000_0000_00, 10'b0000_0000_01, 10'b0000_0000_01,
            10'b0001_0010_01, 10'b0000_0000_00
        };
        i_address = I_ADDR;
        d_address = D_ADDR;
        d_wdata   = D_LINE;

        // Reset holds everything quiet even with requests present.
        rst = 1'b1; i_read = 1'b1; d_read = 1'b0; d_write = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_pmem_read", pmem_read, 0);
        checkOutput("rst_pmem_write", pmem_write, 0);
        checkOutput("rst_pmem_address", pmem_address, 0);
        checkOutput("rst_pmem_wdata", pmem_wdata, 0);
        checkOutput("rst_resps", {i_resp, d_resp}, 0);

        resetDut();
        for (int k = 0; k < 26; k++) begin
            applyStimulus(vecs[k]);
            @(negedge clk);
            exp_addr  = (vecs[k].asel == 2'd1) ? I_ADDR : D_ADDR;
            exp_wdata = (vecs[k].asel == 2'd2) ? D_LINE : '0;
            checkOutput($sformatf("v%0d_pmem_read", k), pmem_read, vecs[k].pr);
            checkOutput($sformatf("v%0d_pmem_write", k), pmem_write, vecs[k].pw);
            checkOutput($sformatf("v%0d_i_resp", k), i_resp, vecs[k].iresp);
            checkOutput($sformatf("v%0d_d_resp", k), d_resp, vecs[k].dresp);
            checkOutput($sformatf("v%0d_pmem_wdata", k), pmem_wdata, exp_wdata);
            if (vecs[k].asel != 2'd0)
                checkOutput($sformatf("v%0d_pmem_address", k), pmem_address, exp_addr);
            if (vecs[k].iresp) checkOutput($sformatf("v%0d_i_rdata", k), i_rdata, AA_LINE);
            if (vecs[k].dresp) checkOutput($sformatf("v%0d_d_rdata", k), d_rdata, AA_LINE);
        end

        // Reset in the middle of a D write-back, then the first tie goes to I.
        resetDut();
        d_write = 1'b1;
        step();
        @(negedge clk);
        checkOutput("rstD_write_live", pmem_write, 1);
        step(); rst = 1'b1;
        step(); rst = 1'b0; i_read = 1'b1;
        @(negedge clk);
        checkOutput("rstD_write_cleared", pmem_write, 0);
        checkOutput("rstD_wdata_cleared", pmem_wdata, 0);
        checkOutput("rstD_read_cleared", pmem_read, 0);
        step();
        @(negedge clk);
        checkOutput("rstD_tie_read", pmem_read, 1);
        checkOutput("rstD_tie_address", pmem_address, I_ADDR);

        // Reset while I is served must hand the next tie back to I.
        resetDut();
        i_read = 1'b1;
        step();
        @(negedge clk);
        checkOutput("rstI_read_live", pmem_read, 1);
        step(); rst = 1'b1; d_read = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        checkOutput("rstI_idle_read", pmem_read, 0);
        step();
        @(negedge clk);
        checkOutput("rstI_tie_address", pmem_address, I_ADDR);
        checkOutput("rstI_tie_read", pmem_read, 1);

        // Fixed priority: D wins twice while I waits.
        resetDut();
        i_read = 1'b1; d_read = 1'b1;
        step(); man_resp_fp = 1'b1;
        @(negedge clk);
        checkOutput("fp_first_address", fp_pmem_address, D_ADDR);
        checkOutput("fp_first_read", fp_pmem_read, 1);
        checkOutput("fp_first_resps", {fp_i_resp, fp_d_resp}, 2'b01);
        step(); man_resp_fp = 1'b0;
        @(negedge clk);
        checkOutput("fp_recover_read", fp_pmem_read, 0);
        step();
        step(); man_resp_fp = 1'b1;
        @(negedge clk);
        checkOutput("fp_second_address", fp_pmem_address, D_ADDR);
        checkOutput("fp_second_d_resp", fp_d_resp, 1);
        step(); man_resp_fp = 1'b0; d_read = 1'b0;
        step();
        step();
        @(negedge clk);
        checkOutput("fp_i_address", fp_pmem_address, I_ADDR);
        checkOutput("fp_i_read", fp_pmem_read, 1);

        // Randomized traffic: continuous contention first, then sparse requests.
        resetDut();
        step();
        mem_auto = 1'b1;
        i_done = 1'b0; d_done = 1'b0;
        prev_active = 1'b0; prev_iw = 1'b0; prev_dw = 1'b0;
        cand_i = 1'b0; cand_d = 1'b0; last_owner = 1'b1;
        gap = 0; i_wait = 0; d_wait = 0; n_i = 0; n_d = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (i_done) begin
                i_read = 1'b0; i_done = 1'b0;
            end else if (!i_read && (cyc < 800 || $urandom_range(0, 2) == 0)) begin
                i_read = 1'b1;
                i_address = 32'h2000 + 32'h20 * $urandom_range(0, 3);
            end
            if (d_done) begin
                d_read = 1'b0; d_write = 1'b0; d_done = 1'b0;
            end else if (!(d_read || d_write) && (cyc < 800 || $urandom_range(0, 2) == 0)) begin
                op = int'($urandom_range(0, 2));
                d_address = 32'h2000 + 32'h20 * $urandom_range(0, 3);
                d_wdata = {8{$urandom}};
                d_read  = (op != 1);
                d_write = (op != 0);
            end

            @(negedge clk);
            active = pmem_read | pmem_write;
            checkOutput("rw_exclusive", pmem_read & pmem_write, 0);
            if (gap > 0) begin
                checkOutput("gap_quiet", active, 0);
                gap--;
            end
            if (active && !prev_active) begin
                cand_i = prev_iw;
                cand_d = prev_dw;
            end
            if (i_resp || d_resp) begin
                checkOutput("one_resp", i_resp & d_resp, 0);
                owner = d_resp;
                exp_owner = (cand_i && cand_d) ? ~last_owner : ~cand_i;
                checkOutput("grant_order", owner, exp_owner);
                checkOutput("resp_address", pmem_address, i_resp ? i_address : d_address);
                last_owner = owner;
                gap = 2;
            end
            if (i_resp) begin
                checkOutput("i_owner", i_read, 1);
                checkOutput("i_rdata", i_rdata, refLine(i_address));
                i_done = 1'b1;
                n_i++;
            end
            if (d_resp) begin
                checkOutput("d_owner", d_read | d_write, 1);
                if (d_write) begin
                    checkOutput("d_wdata", pmem_wdata, d_wdata);
                    ref_mem[d_address] = d_wdata;
                end else begin
                    checkOutput("d_rdata", d_rdata, refLine(d_address));
                end
                d_done = 1'b1;
                n_d++;
            end
            i_wait = (i_read && !i_resp) ? i_wait + 1 : 0;
            d_wait = ((d_read || d_write) && !d_resp) ? d_wait + 1 : 0;
            if (i_wait == 60 || d_wait == 60) begin
                total++;
                bad++;
                $display("[TB] FAIL stall: i waited %0d, d waited %0d, required under 60", i_wait, d_wait);
            end
            prev_active = active;
            prev_iw = i_read;
            prev_dw = d_read | d_write;
        end
        checkOutput("i_progress", n_i > 20, 1);
        checkOutput("d_progress", n_d > 20, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
